filter_out_decimator: RTL and testbench

//  Downstream stage of the digital filter: consumes the filter's 8-bit output sample stream,

---
 rtl/filter_pkg.sv | 8 +
 rtl/sync_fifo.sv | 50 +++++
 rtl/filter_out_decimator.sv | 77 +++++++
 tb/tb_filter_out_decimator.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/filter_pkg.sv
// rtl/filter_pkg.sv - sample format shared by the filter and its output stage
package filter_pkg;

    localparam int DATA_W = 8;

    typedef logic signed [DATA_W-1:0] sample_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through synchronous FIFO with occupancy count
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic              do_push;
    logic              do_pop;

    // Extra MSB on each pointer distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level = wr_ptr - rd_ptr;

    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/filter_out_decimator.sv
// rtl/filter_out_decimator.sv - boxcar decimate-by-R of filter output into a drain FIFO
module filter_out_decimator
    import filter_pkg::*;
#(
    parameter int DATA_W = filter_pkg::DATA_W,
    parameter int LOG2_R = 2,
    parameter int DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic signed [DATA_W-1:0]    y_in,
    input  logic                        y_valid,
    output logic signed [DATA_W-1:0]    dout,
    output logic                        dout_valid,
    input  logic                        dout_ready,
    output logic [$clog2(DEPTH):0]      level,
    output logic                        overflow,
    input  logic                        clr_ovf
);

    localparam int ACC_W = DATA_W + LOG2_R;

    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  sum;
    logic [LOG2_R-1:0]        cnt;
    logic [DATA_W-1:0]        result;
    logic [DATA_W-1:0]        head;
    logic                     last;
    logic                     push;
    logic                     pop;
    logic                     full;
    logic                     empty;
    logic                     drop;

    assign sum  = acc + {{LOG2_R{y_in[DATA_W-1]}}, y_in};
    assign last = &cnt;
    assign push = y_valid & last;
    assign pop  = dout_valid & dout_ready;
    assign drop = push & full & ~pop;

    // Dropping the low LOG2_R bits is the floor-toward-minus-infinity divide by R.
    assign result = sum[ACC_W-1:LOG2_R];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
        end else begin
            if (y_valid) begin
                acc <= last ? '0 : sum;
                cnt <= cnt + 1'b1;
            end
            if (drop)         overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (result),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    assign dout       = head;
    assign dout_valid = ~empty;

endmodule

// File: tb/tb_filter_out_decimator.sv
// tb/tb_filter_out_decimator.sv - bench for filter_out_decimator against a queue-based reference
module tb_filter_out_decimator;
    import filter_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n;
    sample_t            y_in;
    logic               y_valid;
    sample_t            dout;
    logic               dout_valid;
    logic               dout_ready;
    logic [2:0]         level;
    logic               overflow;
    logic               clr_ovf;

    int checks = 0;
    int failures = 0;

    int samp_q[$];
    int res_q[$];
    bit model_ovf;

    typedef struct {
        bit v;
        int y;
        bit rdy;
        int e_dout;
        bit e_valid;
        int e_level;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    filter_out_decimator dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .y_in       (y_in),
        .y_valid    (y_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .level      (level),
        .overflow   (overflow),
        .clr_ovf    (clr_ovf)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int floor_div4(input int s);
        if (s >= 0) return s / 4;
        return -((-s + 3) / 4);
    endfunction

    task automatic check_model();
        chk("model_valid", int'(dout_valid), (res_q.size() > 0) ? 1 : 0);
        chk("model_dout", int'(dout), (res_q.size() > 0) ? res_q[0] : 0);
        chk("model_level", int'(level), res_q.size());
        chk("model_ovf", int'(overflow), int'(model_ovf));
    endtask

    task automatic step(input bit v, input int y, input bit rdy, input bit clr);
        bit pop_m;
        bit push_m;
        int res;
        int s;
        y_valid    = v;
        y_in       = y[7:0];
        dout_ready = rdy;
        clr_ovf    = clr;
        @(posedge clk);
        pop_m  = (res_q.size() > 0) && rdy;
        push_m = 1'b0;
        res    = 0;
        if (v) begin
            samp_q.push_back(y);
            if (samp_q.size() == 4) begin
                s = 0;
                foreach (samp_q[i]) s += samp_q[i];
                res = floor_div4(s);
                push_m = 1'b1;
                samp_q.delete();
            end
        end
        if (push_m && res_q.size() == 4 && !pop_m) model_ovf = 1'b1;
        else begin
            if (clr) model_ovf = 1'b0;
            if (pop_m) void'(res_q.pop_front());
            if (push_m) res_q.push_back(res);
        end
        #1;
        check_model();
    endtask

    task automatic do_reset_pulse();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_dout", int'(dout), 0);
        chk("rst_valid", int'(dout_valid), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_ovf", int'(overflow), 0);
        samp_q.delete();
        res_q.delete();
        model_ovf = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic block(input int val, input bit rdy);
        for (int i = 0; i < 4; i++) step(1'b1, val, rdy, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; y_in = '0; y_valid = 1'b0; dout_ready = 1'b0; clr_ovf = 1'b0;
        model_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("init_valid", int'(dout_valid), 0);
        chk("init_level", int'(level), 0);
        chk("init_ovf", int'(overflow), 0);
        rst_n = 1'b1;

        // Basic, negative and extreme blocks with hand-derived expectations.
        vecs.push_back('{1, 1, 1, 0, 0, 0});
        vecs.push_back('{1, 2, 1, 0, 0, 0});
        vecs.push_back('{1, 3, 1, 0, 0, 0});
        vecs.push_back('{1, 4, 1, 2, 1, 1});
        vecs.push_back('{0, 0, 1, 0, 0, 0});
        vecs.push_back('{1, -1, 1, 0, 0, 0});
        vecs.push_back('{1, -2, 1, 0, 0, 0});
        vecs.push_back('{1, -3, 1, 0, 0, 0});
        vecs.push_back('{1, -4, 1, -3, 1, 1});
        vecs.push_back('{1, 127, 1, 0, 0, 0});
        vecs.push_back('{1, 127, 1, 0, 0, 0});
        vecs.push_back('{1, 127, 1, 0, 0, 0});
        vecs.push_back('{1, 127, 1, 127, 1, 1});
        vecs.push_back('{1, -128, 1, 0, 0, 0});
        vecs.push_back('{1, -128, 1, 0, 0, 0});
        vecs.push_back('{1, -128, 1, 0, 0, 0});
        vecs.push_back('{1, -128, 1, -128, 1, 1});
        vecs.push_back('{0, 0, 1, 0, 0, 0});
        foreach (vecs[i]) begin
            step(vecs[i].v, vecs[i].y, vecs[i].rdy, 1'b0);
            chk($sformatf("vec%0d_dout", i), int'(dout), vecs[i].e_dout);
            chk($sformatf("vec%0d_valid", i), int'(dout_valid), int'(vecs[i].e_valid));
            chk($sformatf("vec%0d_level", i), int'(level), vecs[i].e_level);
        end

        // Backpressure: five blocks into a four-deep FIFO.
        for (int b = 0; b < 5; b++) block(8, 1'b0);
        chk("bp_level", int'(level), 4);
        chk("bp_ovf", int'(overflow), 1);
        for (int i = 0; i < 4; i++) begin
            chk("bp_drain", int'(dout), 8);
            step(1'b0, 0, 1'b1, 1'b0);
        end
        chk("bp_empty", int'(dout_valid), 0);
        chk("bp_ovf_held", int'(overflow), 1);
        step(1'b0, 0, 1'b0, 1'b1);
        chk("bp_clr", int'(overflow), 0);

        // Full FIFO with push and pop on the same edge.
        for (int b = 1; b <= 4; b++) block(b, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 5, 1'b0, 1'b0);
        step(1'b1, 5, 1'b1, 1'b0);
        chk("pp_level", int'(level), 4);
        chk("pp_ovf", int'(overflow), 0);
        for (int e = 2; e <= 5; e++) begin
            chk("pp_order", int'(dout), e);
            step(1'b0, 0, 1'b1, 1'b0);
        end

        // Gapped block matches back-to-back result.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 6 + i, 1'b0, 1'b0);
            step(1'b0, 0, 1'b0, 1'b0);
        end
        chk("gap_dout", int'(dout), 7);
        chk("gap_level", int'(level), 1);

        // Partial block discarded by reset.
        step(1'b1, 50, 1'b0, 1'b0);
        step(1'b1, 50, 1'b0, 1'b0);
        do_reset_pulse();
        block(4, 1'b0);
        chk("rst_blk_dout", int'(dout), 4);
        chk("rst_blk_level", int'(level), 1);
        step(1'b0, 0, 1'b1, 1'b0);

        // Randomised traffic against the reference.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 255) - 128,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
        end
        do_reset_pulse();
        for (int i = 0; i < 100; i++) begin
            step($urandom_range(0, 1) == 1, $urandom_range(0, 255) - 128,
                 $urandom_range(0, 1) == 1, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
